// File: rtl/pwm_output_stage.sv
// pwm_output_stage
// Turns per-pin enable / mode bits and an 8-bit duty request into 16
// registered output pins. Each pin is forced low, static high, or driven by
// one shared PWM waveform. The duty request is shadowed and only taken over
// at a PWM period boundary, so a write arriving mid-period cannot truncate
// or stretch the pulse that is already in flight.
//
// Timing overview (DIV clk cycles per PWM step, 256 steps per period):
//   r_prescaler : 0 .. DIV-1, wraps; w_tick when it sits at DIV-1
//   r_pwm_cnt   : advances on w_tick, 255 -> 0 wrap is the period boundary
//   boundary    : w_tick && r_pwm_cnt == 255
//                 -> r_duty_active <= duty, r_period_start <= 1
//   r_out       : one register stage after the combinational pin mux
//
// DIV must lie in 1..65535 and PRESC_W must be wide enough to hold DIV-1.

module pwm_output_stage #(
    parameter int unsigned DIV     = 3000,
    parameter int unsigned PRESC_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] en_out,
    input  logic [15:0] pwm_mode,
    input  logic [7:0]  duty,
    output logic [15:0] out,
    output logic        period_start,
    output logic [7:0]  duty_active
);

    // Terminal count of the prescaler; truncated to the counter width.
    localparam logic [PRESC_W-1:0] LP_PRESC_MAX = PRESC_W'(DIV - 1);

    // Registered state.
    logic [PRESC_W-1:0] r_prescaler;
    logic [7:0]         r_pwm_cnt;
    logic [7:0]         r_duty_active;
    logic               r_period_start;
    logic [15:0]        r_out;

    // Combinational helpers.
    logic               w_tick;
    logic               w_boundary;
    logic               w_pwm_sig;
    logic [15:0]        w_pwm_vec;
    logic [15:0]        w_out_next;

    // One PWM step every DIV clocks; with DIV = 1 this is every cycle.
    assign w_tick     = (r_prescaler == LP_PRESC_MAX);

    // Last step of the period is ending: start a new period on this edge.
    assign w_boundary = w_tick && (r_pwm_cnt == 8'hFF);

    // Shared waveform. 8'hFF is treated as a true 100% so the pin does not
    // drop for one step at the wrap; 8'h00 naturally yields a constant 0.
    always_comb begin
        w_pwm_sig = 1'b0;
        if (r_duty_active == 8'hFF) begin
            w_pwm_sig = 1'b1;
        end else begin
            w_pwm_sig = (r_pwm_cnt < r_duty_active);
        end
    end

    // Per-pin mux: disabled -> 0, enabled static -> 1, enabled PWM -> waveform.
    assign w_pwm_vec  = {16{w_pwm_sig}};
    assign w_out_next = en_out & (~pwm_mode | w_pwm_vec);

    // Prescaler: free-running divider that produces the PWM step tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prescaler <= '0;
        end else if (w_tick) begin
            r_prescaler <= '0;
        end else begin
            r_prescaler <= r_prescaler + 1'b1;
        end
    end

    // PWM step counter; natural 8-bit wrap gives 255 -> 0 at the boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pwm_cnt <= 8'h00;
        end else if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + 8'h01;
        end
    end

    // Duty shadow register and period-start pulse, both updated at the boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_duty_active  <= 8'h00;
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_boundary;
            if (w_boundary) begin
                r_duty_active <= duty;
            end
        end
    end

    // Output pin register; enable and mode changes show up one clock later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out <= 16'h0000;
        end else begin
            r_out <= w_out_next;
        end
    end

    assign out          = r_out;
    assign period_start = r_period_start;
    assign duty_active  = r_duty_active;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed bench for pwm_output_stage with DIV = 4 (1024 clk per PWM period).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_pwm_output_stage;

  localparam int unsigned DIV    = 4;
  localparam int          PERIOD = 256 * DIV;

  logic        clk;
  logic        rst_n;
  logic [15:0] en_out;
  logic [15:0] pwm_mode;
  logic [7:0]  duty;
  logic [15:0] out;
  logic        period_start;
  logic [7:0]  duty_active;

  int n_chk;
  int n_fail;

  pwm_output_stage #(
    .DIV     (DIV),
    .PRESC_W (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_out       (en_out),
    .pwm_mode     (pwm_mode),
    .duty         (duty),
    .out          (out),
    .period_start (period_start),
    .duty_active  (duty_active)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // single comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // step to the next falling edge until period_start is seen (bounded)
  task automatic wait_period_start(input int budget, output int found, output int cycles);
    found  = 0;
    cycles = 0;
    for (int j = 1; j <= budget; j++) begin
      @(negedge clk);
      cycles = j;
      if (period_start === 1'b1) begin
        found = 1;
        break;
      end
    end
  endtask

  // observe one full PWM period starting right after a period_start sample;
  // optionally change duty on sample index ci (ci = PERIOD - 1 is the
  // boundary cycle itself)
  task automatic run_period(input int ci, input logic [7:0] nd, input logic [7:0] exp_da,
                            output int highs, output int first_low, output int ps_cnt,
                            output int da_bad, output int pin_bad);
    highs     = 0;
    first_low = 0;
    ps_cnt    = 0;
    da_bad    = 0;
    pin_bad   = 0;
    for (int j = 1; j <= PERIOD; j++) begin
      @(negedge clk);
      if (out[0] === 1'b1) highs++;
      else if (first_low == 0) first_low = j;
      if (period_start === 1'b1) ps_cnt++;
      if (j < PERIOD && duty_active !== exp_da) da_bad++;
      if (out[15:12] !== 4'hF || out[11:4] !== 8'h00 ||
          (out[3:0] !== 4'h0 && out[3:0] !== 4'hF)) pin_bad++;
      if (j == ci) duty = nd;
    end
  endtask

  task automatic check_period(input string tag, input int ci, input logic [7:0] nd,
                              input logic [7:0] exp_da, input int exp_highs,
                              input int exp_first_low, input logic [7:0] exp_da_next);
    int highs, first_low, ps_cnt, da_bad, pin_bad;
    run_period(ci, nd, exp_da, highs, first_low, ps_cnt, da_bad, pin_bad);
    chk({tag, "_high_clks"}, highs, exp_highs);
    chk({tag, "_first_low"}, first_low, exp_first_low);
    chk({tag, "_ps_count"}, ps_cnt, 1);
    chk({tag, "_ps_at_end"}, {31'd0, period_start}, 1);
    chk({tag, "_duty_hold"}, da_bad, 0);
    chk({tag, "_pin_align"}, pin_bad, 0);
    chk({tag, "_duty_next"}, {24'd0, duty_active}, {24'd0, exp_da_next});
  endtask

  // directed stimulus
  initial begin
    int found, cycles, highs;
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    en_out   = 16'hFFFF;
    pwm_mode = 16'h0000;
    duty     = 8'h00;

    // reset held for 3 clocks
    repeat (3) @(negedge clk);
    chk("rst_out", {16'd0, out}, 32'h0);
    chk("rst_duty_active", {24'd0, duty_active}, 32'h0);
    chk("rst_period_start", {31'd0, period_start}, 32'h0);
    chk("rst_pwm_cnt", {24'd0, dut.r_pwm_cnt}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_out_static", {16'd0, out}, 32'hFFFF);

    // static / enable mux
    en_out = 16'h00F0;
    @(negedge clk);
    chk("mux_en_00f0", {16'd0, out}, 32'h00F0);
    en_out = 16'h0000;
    @(negedge clk);
    chk("mux_en_clear", {16'd0, out}, 32'h0);

    // PWM on pins 3:0, static high on 15:12, 50% requested
    en_out   = 16'hF00F;
    pwm_mode = 16'h000F;
    duty     = 8'h80;
    wait_period_start(2 * PERIOD, found, cycles);
    chk("first_boundary_found", found, 1);
    chk("first_boundary_delay", cycles, PERIOD - 3);
    chk("first_duty_active", {24'd0, duty_active}, 32'h80);

    // 50%, then a boundary-cycle write of 00
    check_period("d80", PERIOD - 1, 8'h00, 8'h80, 512, 513, 8'h00);
    // 0% for two periods, then a boundary-cycle write of FF
    check_period("d00_a", -1, 8'h00, 8'h00, 0, 1, 8'h00);
    check_period("d00_b", PERIOD - 1, 8'hFF, 8'h00, 0, 1, 8'hFF);
    // 100% for two periods, no low cycle across the wrap
    check_period("dff_a", -1, 8'hFF, 8'hFF, PERIOD, 0, 8'hFF);
    check_period("dff_b", PERIOD - 1, 8'h40, 8'hFF, PERIOD, 0, 8'h40);
    // shadow: mid-period write of C0 does not disturb the 40 period
    check_period("d40", 100, 8'hC0, 8'h40, 64 * DIV, 257, 8'hC0);
    // boundary-cycle write of 20 takes effect in the next period
    check_period("dc0", PERIOD - 1, 8'h20, 8'hC0, 192 * DIV, 769, 8'h20);
    check_period("d20", PERIOD - 1, 8'hC0, 8'h20, 32 * DIV, 129, 8'hC0);

    // reset in the middle of a C0 period at pwm_cnt = 100
    repeat (100 * DIV) @(negedge clk);
    chk("pre_rst_cnt", {24'd0, dut.r_pwm_cnt}, 32'd100);
    chk("pre_rst_duty_active", {24'd0, duty_active}, 32'hC0);
    chk("pre_rst_out", {16'd0, out}, 32'hF00F);
    rst_n = 1'b0;
    duty  = 8'h60;
    @(negedge clk);
    chk("mid_rst_out", {16'd0, out}, 32'h0);
    chk("mid_rst_cnt", {24'd0, dut.r_pwm_cnt}, 32'h0);
    chk("mid_rst_duty_active", {24'd0, duty_active}, 32'h0);
    chk("mid_rst_period_start", {31'd0, period_start}, 32'h0);
    rst_n = 1'b1;

    // first period after reset: PWM pins stay low
    found = 0;
    highs = 0;
    for (int j = 1; j <= PERIOD + 100; j++) begin
      @(negedge clk);
      if (out[0] === 1'b1) highs++;
      if (period_start === 1'b1) begin
        found = j;
        break;
      end
    end
    chk("post_rst_boundary_at", found, PERIOD);
    chk("post_rst_pwm_low", highs, 0);
    chk("post_rst_duty_active", {24'd0, duty_active}, 32'h60);
    check_period("d60", -1, 8'h60, 8'h60, 96 * DIV, 385, 8'h60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
